// File: rtl/hangman_display_pkg.sv
// Shared state encoding and ASCII constants for the hangman LCD formatter.
package hangman_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } hangman_state_e;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [7:0] UNDERSCORE = 8'h5F;
  localparam logic [7:0] CHAR_A     = 8'h41;
  localparam logic [7:0] CHAR_Z     = 8'h5A;

  localparam logic [23:0] WIN_STR  = "WIN";
  localparam logic [31:0] LOSE_STR = "LOSE";

endpackage

// File: rtl/hangman_row_center.sv
// Places an N-character packed string centred in a COLS-character row of spaces.
module hangman_row_center
  import hangman_display_pkg::*;
#(
  parameter int N    = 5,
  parameter int COLS = 16
) (
  input  logic [8*N-1:0]    str,
  output logic [8*COLS-1:0] row
);

  // Left pad rounds down, so odd leftovers land on the right.
  localparam int PAD = (COLS - N) / 2;

  always_comb begin
    row = {COLS{SPACE}};
    for (int i = 0; i < N; i++) begin
      row[8*(COLS-1-PAD-i) +: 8] = str[8*(N-1-i) +: 8];
    end
  end

endmodule

// File: rtl/hangman_host_display_gen2.sv
// Hangman game engine and two-row ASCII formatter feeding the LCD driver.
//   state | meaning
//   IDLE  | no game, both rows blank
//   PLAY  | accepting guesses, word cells on top, misses below
//   WIN   | all cells revealed, "WIN" over the word
//   LOSE  | miss budget exhausted, "LOSE" over the word
module hangman_host_display_gen2
  import hangman_display_pkg::*;
#(
  parameter int WORD_LEN   = 5,
  parameter int MAX_MISSES = 6,
  parameter int LCD_COLS   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              new_game,
  input  logic                              end_game,
  input  logic [8*WORD_LEN-1:0]             word,
  input  logic                              guess_valid,
  input  logic [7:0]                        guess_letter,
  output logic                              guess_ready,
  output logic [8*LCD_COLS-1:0]             top,
  output logic [8*LCD_COLS-1:0]             bottom,
  output logic [1:0]                        state,
  output logic [$clog2(MAX_MISSES+1)-1:0]   miss_count,
  output logic                              dup_guess,
  output logic                              bad_guess,
  output logic                              disp_update
);

  localparam int CW = $clog2(MAX_MISSES + 1);

  hangman_state_e              state_q, state_d;
  logic [8*WORD_LEN-1:0]       word_q;
  logic [WORD_LEN-1:0]         revealed_q, revealed_d;
  logic [8*MAX_MISSES-1:0]     misses_q, misses_d;
  logic [CW-1:0]               miss_cnt_q, miss_cnt_d;
  logic                        dup_d, bad_d;
  logic                        accept, is_alpha, in_misses;
  logic [WORD_LEN-1:0]         match;
  logic [8*WORD_LEN-1:0]       cells;
  logic [8*LCD_COLS-1:0]       cells_row, miss_row, word_row, win_row, lose_row;
  logic [8*LCD_COLS-1:0]       top_d, bottom_d;

  assign guess_ready = (state_q == ST_PLAY);
  assign accept      = guess_valid && guess_ready;
  assign is_alpha    = (guess_letter >= CHAR_A) && (guess_letter <= CHAR_Z);
  assign state       = state_q;
  assign miss_count  = miss_cnt_q;

  always_comb begin
    in_misses = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      match[i]              = (word_q[8*(WORD_LEN-1-i) +: 8] == guess_letter);
      cells[8*(WORD_LEN-1-i) +: 8] = revealed_q[i] ? word_q[8*(WORD_LEN-1-i) +: 8] : UNDERSCORE;
    end
    // Empty slots hold '_', which never equals a letter that passed is_alpha.
    for (int j = 0; j < MAX_MISSES; j++) begin
      if (misses_q[8*(MAX_MISSES-1-j) +: 8] == guess_letter) in_misses = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    misses_d   = misses_q;
    miss_cnt_d = miss_cnt_q;
    dup_d      = 1'b0;
    bad_d      = 1'b0;
    if (end_game || new_game) begin
      state_d    = end_game ? ST_IDLE : ST_PLAY;
      revealed_d = '0;
      misses_d   = {MAX_MISSES{UNDERSCORE}};
      miss_cnt_d = '0;
    end else if (accept) begin
      if (!is_alpha) begin
        bad_d = 1'b1;
      end else if (|match) begin
        if ((match & ~revealed_q) == '0) dup_d = 1'b1;
        else                             revealed_d = revealed_q | match;
      end else if (in_misses) begin
        dup_d = 1'b1;
      end else begin
        for (int j = 0; j < MAX_MISSES; j++) begin
          if (CW'(j) == miss_cnt_q) misses_d[8*(MAX_MISSES-1-j) +: 8] = guess_letter;
        end
        miss_cnt_d = miss_cnt_q + CW'(1);
      end
      if (&revealed_d)                          state_d = ST_WIN;
      else if (miss_cnt_d == CW'(MAX_MISSES))   state_d = ST_LOSE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= {WORD_LEN{UNDERSCORE}};
      revealed_q <= '0;
      misses_q   <= {MAX_MISSES{UNDERSCORE}};
      miss_cnt_q <= '0;
      dup_guess  <= 1'b0;
      bad_guess  <= 1'b0;
    end else begin
      state_q    <= state_d;
      revealed_q <= revealed_d;
      misses_q   <= misses_d;
      miss_cnt_q <= miss_cnt_d;
      dup_guess  <= dup_d;
      bad_guess  <= bad_d;
      if (new_game && !end_game) word_q <= word;
    end
  end

  hangman_row_center #(.N(WORD_LEN),   .COLS(LCD_COLS)) u_cells_row (.str(cells),    .row(cells_row));
  hangman_row_center #(.N(MAX_MISSES), .COLS(LCD_COLS)) u_miss_row  (.str(misses_q), .row(miss_row));
  hangman_row_center #(.N(WORD_LEN),   .COLS(LCD_COLS)) u_word_row  (.str(word_q),   .row(word_row));
  hangman_row_center #(.N(3),          .COLS(LCD_COLS)) u_win_row   (.str(WIN_STR),  .row(win_row));
  hangman_row_center #(.N(4),          .COLS(LCD_COLS)) u_lose_row  (.str(LOSE_STR), .row(lose_row));

  always_comb begin
    top_d    = {LCD_COLS{SPACE}};
    bottom_d = {LCD_COLS{SPACE}};
    case (state_q)
      ST_PLAY: begin top_d = cells_row; bottom_d = miss_row; end
      ST_WIN:  begin top_d = win_row;   bottom_d = word_row; end
      ST_LOSE: begin top_d = lose_row;  bottom_d = word_row; end
      default: ;
    endcase
  end

  // Rows lag game state by one edge; disp_update is registered alongside them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top         <= {LCD_COLS{SPACE}};
      bottom      <= {LCD_COLS{SPACE}};
      disp_update <= 1'b0;
    end else begin
      top         <= top_d;
      bottom      <= bottom_d;
      disp_update <= (top_d != top) || (bottom_d != bottom);
    end
  end

endmodule

// File: tb/tb_hangman_host_display_gen2.sv
// Directed bench for hangman_host_display_gen2 with hand-computed row images.
module tb_hangman_host_display_gen2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_game = 1'b0;
  logic         end_game = 1'b0;
  logic [39:0]  word = "APPLE";
  logic         guess_valid = 1'b0;
  logic [7:0]   guess_letter = 8'h00;
  logic         guess_ready;
  logic [127:0] top, bottom;
  logic [1:0]   state;
  logic [2:0]   miss_count;
  logic         dup_guess, bad_guess, disp_update;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] BLANK = {16{8'h20}};

  hangman_host_display_gen2 #(.WORD_LEN(5), .MAX_MISSES(6), .LCD_COLS(16)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .end_game(end_game), .word(word),
    .guess_valid(guess_valid), .guess_letter(guess_letter), .guess_ready(guess_ready),
    .top(top), .bottom(bottom), .state(state), .miss_count(miss_count),
    .dup_guess(dup_guess), .bad_guess(bad_guess), .disp_update(disp_update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic guess(input logic [7:0] c);
    guess_valid  = 1'b1;
    guess_letter = c;
    tick();
    guess_valid  = 1'b0;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_state", 128'(state), 128'(0));
    check("rst_top", top, BLANK);
    check("rst_bottom", bottom, BLANK);
    check("rst_miss", 128'(miss_count), 128'(0));
    check("rst_ready", 128'(guess_ready), 128'(0));
    check("rst_pulses", 128'({dup_guess, bad_guess, disp_update}), 128'(0));
    rst = 1'b0;
    tick();

    // Game 1: reveal, duplicates, bad guess, win
    start_game();
    check("g1_state_play", 128'(state), 128'(1));
    check("g1_ready", 128'(guess_ready), 128'(1));
    check("g1_top_lag", top, BLANK);
    check("g1_disp_lag", 128'(disp_update), 128'(0));
    word = "ZZZZZ";
    tick();
    check("g1_top_init", top, "     _____      ");
    check("g1_bot_init", bottom, "     ______     ");
    check("g1_disp_init", 128'(disp_update), 128'(1));
    tick();
    check("g1_disp_clear", 128'(disp_update), 128'(0));

    guess("P");
    check("p1_dup", 128'(dup_guess), 128'(0));
    check("p1_bad", 128'(bad_guess), 128'(0));
    tick();
    check("p1_top", top, "     _PP__      ");
    check("p1_disp", 128'(disp_update), 128'(1));
    guess("P");
    check("p2_dup", 128'(dup_guess), 128'(1));
    check("p2_miss", 128'(miss_count), 128'(0));
    tick();
    check("p2_dup_end", 128'(dup_guess), 128'(0));
    check("p2_top", top, "     _PP__      ");
    check("p2_disp", 128'(disp_update), 128'(0));

    guess("X");
    check("x1_miss", 128'(miss_count), 128'(1));
    check("x1_dup", 128'(dup_guess), 128'(0));
    tick();
    check("x1_bot", bottom, "     X_____     ");
    guess("X");
    check("x2_dup", 128'(dup_guess), 128'(1));
    check("x2_miss", 128'(miss_count), 128'(1));
    guess("q");
    check("q_bad", 128'(bad_guess), 128'(1));
    check("q_dup", 128'(dup_guess), 128'(0));
    check("q_miss", 128'(miss_count), 128'(1));
    tick();
    check("q_bad_end", 128'(bad_guess), 128'(0));

    guess("A");
    tick();
    check("a_top", top, "     APP__      ");
    guess("L");
    check("l_state", 128'(state), 128'(1));
    guess("E");
    check("win_state", 128'(state), 128'(2));
    check("win_ready", 128'(guess_ready), 128'(0));
    tick();
    check("win_top", top, "      WIN       ");
    check("win_bot", bottom, "     APPLE      ");
    check("win_disp", 128'(disp_update), 128'(1));
    guess("Z");
    check("win_hold_state", 128'(state), 128'(2));
    check("win_hold_miss", 128'(miss_count), 128'(1));
    check("win_hold_dup", 128'(dup_guess), 128'(0));

    // Game 2: guess dropped under new_game, held valid, loss
    word = "APPLE";
    new_game = 1'b1; guess_valid = 1'b1; guess_letter = "B";
    tick();
    new_game = 1'b0; guess_valid = 1'b0;
    check("g2_state", 128'(state), 128'(1));
    check("g2_drop_miss", 128'(miss_count), 128'(0));
    guess_valid = 1'b1; guess_letter = "B";
    tick();
    check("hold1_miss", 128'(miss_count), 128'(1));
    check("hold1_dup", 128'(dup_guess), 128'(0));
    tick();
    guess_valid = 1'b0;
    check("hold2_dup", 128'(dup_guess), 128'(1));
    check("hold2_miss", 128'(miss_count), 128'(1));
    guess("C"); guess("D"); guess("F"); guess("G");
    check("five_miss", 128'(miss_count), 128'(5));
    check("five_state", 128'(state), 128'(1));
    guess("H");
    check("lose_state", 128'(state), 128'(3));
    check("lose_miss", 128'(miss_count), 128'(6));
    check("lose_ready", 128'(guess_ready), 128'(0));
    tick();
    check("lose_top", top, "      LOSE      ");
    check("lose_bot", bottom, "     APPLE      ");

    // Game 3: end_game beats new_game
    start_game();
    guess("X");
    check("g3_miss", 128'(miss_count), 128'(1));
    new_game = 1'b1; end_game = 1'b1;
    tick();
    new_game = 1'b0; end_game = 1'b0;
    check("prio_state", 128'(state), 128'(0));
    check("prio_miss", 128'(miss_count), 128'(0));
    check("prio_ready", 128'(guess_ready), 128'(0));
    tick();
    check("prio_top", top, BLANK);
    check("prio_bot", bottom, BLANK);
    check("prio_disp", 128'(disp_update), 128'(1));

    // Game 4: async reset mid-play
    start_game();
    guess("X");
    tick();
    check("g4_bot", bottom, "     X_____     ");
    guess("X");
    check("g4_dup", 128'(dup_guess), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_state", 128'(state), 128'(0));
    check("arst_miss", 128'(miss_count), 128'(0));
    check("arst_top", top, BLANK);
    check("arst_bot", bottom, BLANK);
    check("arst_dup", 128'(dup_guess), 128'(0));
    check("arst_ready", 128'(guess_ready), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_state", 128'(state), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hangman_host_display_gen2.md
Name: hangman_host_display_gen2

Overview:
- Parametrised successor to the host-side hangman LCD formatter.
- Latches the secret word at game start and matches each guessed letter against it internally.
- Tracks revealed cells, miss history, duplicate and invalid guesses, and win/loss state.
- Drives two registered 16x2-style ASCII rows; sits between the guess receiver (UART/RF side) and the LCD driver.

Parameters:
- WORD_LEN, 5: letters in the secret word; 1..LCD_COLS.
- MAX_MISSES, 6: misses allowed before loss; 1..LCD_COLS.
- LCD_COLS, 16: characters per LCD row; >= 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- new_game  in  1  pulse: latch word, clear progress, enter PLAY
- end_game  in  1  pulse: abandon game, enter IDLE, blank display
- word  in  8*WORD_LEN  secret word in ASCII; char 0 (leftmost) in MSB byte; sampled only on new_game
- guess_valid  in  1  guess offered
- guess_letter  in  8  ASCII guess
- guess_ready  out  1  high only in PLAY
- top  out  8*LCD_COLS  LCD row 1; column 0 in MSB byte
- bottom  out  8*LCD_COLS  LCD row 2
- state  out  2  IDLE=0, PLAY=1, WIN=2, LOSE=3
- miss_count  out  $clog2(MAX_MISSES+1)  misses so far
- dup_guess  out  1  1-cycle pulse: accepted guess already used
- bad_guess  out  1  1-cycle pulse: accepted guess not 'A'..'Z'
- disp_update  out  1  1-cycle pulse coincident with any change of top/bottom

Behaviour:
- Reset:
  - state=IDLE, top/bottom all 8'h20, miss_count=0, pulses 0.
  - Word cells all '_' (8'h5F); miss list all '_'.
- Accept = guess_valid & guess_ready.
- Priority within one cycle: end_game > new_game > accept. A lower-priority event is dropped, not queued.
- new_game (any state):
  - Latch word; word cells '_'; miss list '_'; miss_count=0; state=PLAY.
- end_game (any state): state=IDLE; cells/list cleared as at reset.
- Guess classification (PLAY only):
  - Not in 'A'..'Z': bad_guess=1; no other state change.
  - Matches >=1 latched char: reveal every matching position. If all matching positions were already revealed, dup_guess=1 and nothing changes.
  - Matches none: if the letter is already in the miss list, dup_guess=1. Otherwise write it to miss slot miss_count (slots fill left to right) and increment miss_count.
  - Lowercase is not folded; it is a bad guess.
- End conditions, evaluated on the post-guess values:
  - All WORD_LEN cells revealed -> WIN.
  - Otherwise miss_count==MAX_MISSES -> LOSE.
  - A win takes precedence if both would hold (cannot occur with a single guess; stated for completeness).
- WIN/LOSE: guess_ready=0; held until new_game, end_game or rst.
- Row content, all registered; centring pad L = (LCD_COLS-n)/2 (floor), rest space-filled:
  - IDLE: both rows spaces.
  - PLAY: top = word cells centred (n=WORD_LEN); bottom = miss list centred (n=MAX_MISSES).
  - WIN: top = "WIN" centred; bottom = latched word centred.
  - LOSE: top = "LOSE" centred; bottom = latched word centred.
- Latency:
  - Event at edge k -> state, counters and cells update at edge k.
  - top/bottom reflect the change at edge k+1.
  - disp_update pulses in the cycle top/bottom first show new content.
  - dup_guess/bad_guess pulse in the cycle after the accept edge.
- guess_letter is sampled only at the accept edge; guess_valid held across several cycles counts as one guess per accepting cycle.
- Async rst asserted mid-game aborts immediately; no pending event survives.

Decomposition:
- hangman_display_pkg:
  - state enum (IDLE/PLAY/WIN/LOSE).
  - ASCII constants: SPACE 8'h20, UNDERSCORE 8'h5F, 'A' 8'h41, 'Z' 8'h5A.
  - WIN_STR "WIN" and LOSE_STR "LOSE" as packed ASCII.
- Sub-module hangman_row_center (params N, COLS):
  - Combinational; places an N-char packed string centred in a COLS-char row padded with spaces.
  - Instantiated once per row source.

Test Plan:
- rst, then new_game with word="APPLE" -> at next edge state=PLAY; top = 5 spaces,"_____",6 spaces; bottom = 5 spaces,"______",5 spaces.
- Guess 'P' then 'P' again -> top shows "_PP__"; second guess gives dup_guess=1, miss_count unchanged, top unchanged.
- Guesses 'X','X','q' -> miss_count=1; bottom "X_____" centred; second 'X' gives dup_guess; 'q' gives bad_guess; miss_count stays 1.
- Guesses A,P,L,E -> state=WIN after 'E'; top "WIN" at cols 6-8; bottom "APPLE" at cols 5-9; guess_ready=0.
- Six distinct misses B,C,D,F,G,H -> state=LOSE on the 6th; top "LOSE" at cols 6-9; bottom "APPLE"; miss_count=6.
- new_game and end_game in the same cycle mid-PLAY -> IDLE, rows blank. Also assert rst mid-PLAY -> all outputs at reset values immediately.
